// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: RV32 load/store funct3
// codes, controller states and the funct3 legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic is_valid_funct3(input logic we, input logic [2:0] f3);
    logic sized;
    sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (we) return sized;
    return sized || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: merges store data into the old
// word, builds byte enables, extends load data and flags misalignment.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] st_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the store data puts it on every lane; the enables pick one.
  always_comb begin
    st_src = wdata;
    st_be  = 4'b0000;
    case (funct3)
      F3_B: begin
        st_src = {4{wdata[7:0]}};
        st_be  = 4'b0001 << addr_lo;
      end
      F3_H: begin
        st_src = {2{wdata[15:0]}};
        st_be  = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        st_src = wdata;
        st_be  = 4'b1111;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign st_word[8*gi +: 8] = st_be[gi] ? st_src[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = old_word[{addr_lo, 3'b000} +: 8];
  assign ld_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    ld_data    = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU: ld_data = {24'h0, ld_byte};
      F3_H: begin
        ld_data    = {{16{ld_half[15]}}, ld_half};
        misaligned = addr_lo[0];
      end
      F3_HU: begin
        ld_data    = {16'h0, ld_half};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        ld_data    = old_word;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory behind a valid/ready request port with a
// configurable-latency, single-cycle response pulse and RV32 sub-word access.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_mem_ctrl: DATA_WIDTH must be 32");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be at least 1");
  end
  if (DEPTH < 2 || IDX_W + 2 > ADDR_WIDTH) begin : g_bad_depth
    $error("data_mem_ctrl: DEPTH does not fit the byte address");
  end

  function automatic logic [DEPTH-1:0][DATA_WIDTH-1:0] ram_init();
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i] = DATA_WIDTH'(i);
    return r;
  endfunction

  // Power-up contents word[i] = i; reset never touches the array.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ram = ram_init();

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic                  cap_we_reg;
  logic [2:0]            cap_f3_reg;
  logic [ADDR_WIDTH-1:0] cap_addr_reg;
  logic [DATA_WIDTH-1:0] cap_wdata_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;

  logic                  accept, enter_resp, wr_en;
  logic                  op_we, op_err, misaligned, range_err;
  logic [2:0]            op_f3;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata, old_word, st_word, ld_data;
  logic [3:0]            st_be;
  logic [IDX_W-1:0]      idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
        else cnt_next = cnt_reg - 1'b1;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_next == RESP);

  // With single-cycle latency the RESP edge is the accept edge, so the
  // operation comes straight from the request port instead of the capture.
  always_comb begin
    op_we    = cap_we_reg;
    op_f3    = cap_f3_reg;
    op_addr  = cap_addr_reg;
    op_wdata = cap_wdata_reg;
    if (state_reg == IDLE) begin
      op_we    = req_we;
      op_f3    = req_funct3;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  assign idx       = op_addr[IDX_W+1:2];
  assign old_word  = ram[idx];
  assign range_err = (op_addr >> 2) >= DEPTH_A;
  assign op_err    = range_err || misaligned || !is_valid_funct3(op_we, op_f3);
  assign wr_en     = enter_resp && op_we && !op_err && !rst;

  mem_lane_align u_align (
    .funct3     (op_f3),
    .addr_lo    (op_addr[1:0]),
    .old_word   (old_word),
    .wdata      (op_wdata),
    .st_word    (st_word),
    .st_be      (st_be),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) ram[idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we_reg    <= 1'b0;
      cap_f3_reg    <= '0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we_reg    <= req_we;
        cap_f3_reg    <= req_funct3;
        cap_addr_reg  <= req_addr;
        cap_wdata_reg <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err_reg   <= op_err;
        rsp_rdata_reg <= (op_err || op_we) ? '0 : ld_data;
      end
    end
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (LATENCY 2, 1 and 4)
// sharing clock and reset, checked with immediate assertions.
module tb_data_mem_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int total = 0;
  int bad   = 0;
  int pulses2 = 0;
  int pulses_before;

  data_mem_ctrl #(.DEPTH(128), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_ctrl #(.DEPTH(128), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  data_mem_ctrl #(.DEPTH(128), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge rsp_valid[2]) pulses2++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance s; checks handshake, latency, response and hold.
  task automatic xact(input int s, input int lat, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int n;
    @(negedge clk);
    chk({name, " ready_before"}, 32'(req_ready[s]), 32'd1);
    req_valid[s]  = 1'b1;
    req_we[s]     = we;
    req_funct3[s] = f3;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    @(posedge clk);
    #1;
    // Scramble the request port: it must be ignored while busy.
    req_valid[s]  = 1'b0;
    req_we[s]     = ~we;
    req_funct3[s] = 3'b111;
    req_addr[s]   = 32'h0000_0004;
    req_wdata[s]  = 32'hFFFF_FFFF;
    n = 1;
    while (rsp_valid[s] !== 1'b1 && n < 12) begin
      chk({name, " busy_ready"}, 32'(req_ready[s]), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " rsp_ready"}, 32'(req_ready[s]), 32'd0);
    chk({name, " err"}, 32'(rsp_err[s]), 32'(exp_err));
    chk({name, " rdata"}, rsp_rdata[s], exp_rdata);
    $display("xact %s: inst=%0d lat=%0d rdata=%h err=%b", name, s, n, rsp_rdata[s], rsp_err[s]);
    @(posedge clk);
    #1;
    chk({name, " pulse_end"}, 32'(rsp_valid[s]), 32'd0);
    chk({name, " ready_after"}, 32'(req_ready[s]), 32'd1);
    chk({name, " rdata_hold"}, rsp_rdata[s], exp_rdata);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      req_valid[s]  = 1'b0;
      req_we[s]     = 1'b0;
      req_funct3[s] = 3'b000;
      req_addr[s]   = '0;
      req_wdata[s]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset ready", 32'(req_ready[s]), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset rdata", rsp_rdata[s], 32'd0);
      chk("reset err", 32'(rsp_err[s]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // LATENCY = 2: stores, full and sub-word loads, errors.
    xact(0, 2, 1'b1, LW,  32'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "sw_8");
    xact(0, 2, 1'b0, LW,  32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, "lw_8");
    xact(0, 2, 1'b0, LB,  32'h0B, 32'h0,         32'hFFFF_FFDE, 1'b0, "lb_b");
    xact(0, 2, 1'b0, LBU, 32'h0B, 32'h0,         32'h0000_00DE, 1'b0, "lbu_b");
    xact(0, 2, 1'b0, LH,  32'h0A, 32'h0,         32'hFFFF_DEAD, 1'b0, "lh_a");
    xact(0, 2, 1'b0, LHU, 32'h08, 32'h0,         32'h0000_BEEF, 1'b0, "lhu_8");
    xact(0, 2, 1'b1, LB,  32'h09, 32'hFFFF_FF55, 32'h0000_0000, 1'b0, "sb_9");
    xact(0, 2, 1'b0, LW,  32'h08, 32'h0,         32'hDEAD_55EF, 1'b0, "lw_8_after_sb");
    xact(0, 2, 1'b1, LH,  32'h0E, 32'hABCD_1234, 32'h0000_0000, 1'b0, "sh_e");
    xact(0, 2, 1'b0, LW,  32'h0C, 32'h0,         32'h1234_0003, 1'b0, "lw_c_after_sh");
    xact(0, 2, 1'b0, LW,  32'h06, 32'h0,         32'h0000_0000, 1'b1, "lw_6_misaligned");
    xact(0, 2, 1'b1, LH,  32'h05, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "sh_5_misaligned");
    xact(0, 2, 1'b0, LW,  32'h04, 32'h0,         32'h0000_0001, 1'b0, "lw_4_unchanged");
    xact(0, 2, 1'b0, LW,  32'h200, 32'h0,        32'h0000_0000, 1'b1, "lw_200_range");
    xact(0, 2, 1'b0, LW,  32'h1FC, 32'h0,        32'h0000_007F, 1'b0, "lw_1fc_last");
    xact(0, 2, 1'b0, 3'b011, 32'h00, 32'h0,      32'h0000_0000, 1'b1, "f3_011");
    xact(0, 2, 1'b1, LHU, 32'h00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "store_f3_101");
    xact(0, 2, 1'b0, LW,  32'h00, 32'h0,         32'h0000_0000, 1'b0, "lw_0_unchanged");

    // LATENCY = 4: reset during WAIT discards the store.
    pulses_before = pulses2;
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_we[2]     = 1'b1;
    req_funct3[2] = LW;
    req_addr[2]   = 32'h10;
    req_wdata[2]  = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    chk("abort accepted", 32'(req_ready[2]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort rsp_valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort no_pulse", 32'(pulses2), 32'(pulses_before));
    chk("abort ready_after", 32'(req_ready[2]), 32'd1);
    $display("xact abort_sw_10: inst=2 pulses=%0d ready=%b", pulses2 - pulses_before, req_ready[2]);
    xact(2, 4, 1'b0, LW, 32'h10, 32'h0, 32'h0000_0004, 1'b0, "lw_10_after_abort");
    chk("abort one_pulse", 32'(pulses2), 32'(pulses_before + 1));

    // LATENCY = 1: req_valid held high across three loads.
    @(negedge clk);
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_funct3[1] = LW;
    req_addr[1]   = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("b2b rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("b2b busy_ready", 32'(req_ready[1]), 32'd0);
      chk("b2b rdata", rsp_rdata[1], 32'(k));
      $display("xact b2b_lw_%0d: inst=1 rdata=%h err=%b", k, rsp_rdata[1], rsp_err[1]);
      req_addr[1] = 32'(4 * (k + 1));
      if (k == 2) req_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b idle_valid", 32'(rsp_valid[1]), 32'd0);
      chk("b2b idle_ready", 32'(req_ready[1]), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("b2b no_extra", 32'(rsp_valid[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
